// File: rtl/dl_mul_pkg.sv
// Shared definitions for the dl_* multiplier family.
// The shift-add multiplier uses these today. Booth and radix-4 variants are meant to reuse them.
package dl_mul_pkg;

  // Controller states shared by every iterative multiplier variant.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_NUM_BITS = 32;

  // Width of a full unsigned product of two n-bit operands.
  function automatic int prod_width(input int n);
    return 2 * n;
  endfunction

endpackage

// File: rtl/dl_lshift.sv
// Library logical left shifter (combinational). Vacated low bits are zero-filled.
module dl_lshift #(
  parameter int NUM_BITS = 64
) (
  input  logic [NUM_BITS-1:0]         data,
  input  logic [$clog2(NUM_BITS)-1:0] shamt,
  output logic [NUM_BITS-1:0]         out
);

  assign out = data << shamt;

endmodule

// File: rtl/dl_shift_add_mul.sv
// Iterative radix-2 shift-and-add unsigned multiplier.
// It retires one multiplier bit per cycle and stops early once the remaining multiplier bits are zero.
// Operands arrive over a valid/ready handshake. The product leaves over a second one.
module dl_shift_add_mul
  import dl_mul_pkg::*;
#(
  parameter int NUM_BITS = DEFAULT_NUM_BITS
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_val,
  output logic                           in_rdy,
  input  logic [NUM_BITS-1:0]            a,
  input  logic [NUM_BITS-1:0]            b,
  output logic                           out_val,
  input  logic                           out_rdy,
  output logic [prod_width(NUM_BITS)-1:0] out
);

  localparam int NUM_CNT_BITS = $clog2(NUM_BITS) + 1;
  localparam int PROD_BITS    = prod_width(NUM_BITS);
  localparam int SHAMT_BITS   = $clog2(PROD_BITS);

  state_t                  state;
  logic [PROD_BITS-1:0]    a_reg;
  logic [PROD_BITS-1:0]    a_shl;
  logic [PROD_BITS-1:0]    acc;
  logic [NUM_BITS-1:0]     b_reg;
  logic [NUM_BITS-1:0]     b_next;
  logic [NUM_CNT_BITS-1:0] cnt;
  logic                    calc_last;

  // The multiplicand doubles every step, so it is a fixed shift by one.
  dl_lshift #(
    .NUM_BITS(PROD_BITS)
  ) u_lshift (
    .data (a_reg),
    .shamt(SHAMT_BITS'(1)),
    .out  (a_shl)
  );

  // Decide whether this CALC step retires the last useful multiplier bit.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    b_next    = b_reg >> 1;
    calc_last = 1'b0;
    if ((b_next == '0) || (cnt == NUM_CNT_BITS'(NUM_BITS - 1))) begin
      calc_last = 1'b1;
    end
  end

  // Controller, datapath registers and registered handshake outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
    if (rst) begin
      state   <= IDLE;
      a_reg   <= '0;
      b_reg   <= '0;
      acc     <= '0;
      cnt     <= '0;
      in_rdy  <= 1'b1;
      out_val <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_val && in_rdy) begin
            a_reg  <= {{NUM_BITS{1'b0}}, a};
            b_reg  <= b;
            acc    <= '0;
            cnt    <= '0;
            in_rdy <= 1'b0;
            state  <= CALC;
          end
        end
        CALC: begin
          if (b_reg[0]) begin
            acc <= acc + a_reg;
          end
          a_reg <= a_shl;
          b_reg <= b_next;
          cnt   <= cnt + NUM_CNT_BITS'(1);
          if (calc_last) begin
            out_val <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          if (out_rdy) begin
            out_val <= 1'b0;
            in_rdy  <= 1'b1;
            state   <= IDLE;
          end
        end
        default: begin
          in_rdy  <= 1'b1;
          out_val <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign out = acc;

endmodule
